data_mem_unit: RTL and testbench



---
 rtl/data_mem_unit_if.sv | 36 +++
 rtl/data_mem_unit.sv | 211 +++++++++++++++++++++
 tb/tb_data_mem_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_unit_if
// Description : Memory-stage bus between the E->M pipeline register / hazard
//               logic (master) and the data-memory controller (slave).
//   MemReadM    load request
//   MemWriteM   store request
//   Funct3M     RV32I load/store funct3 (size and sign)
//   AddressM    byte address from the ALU
//   WriteDataM  store data (low bytes used for SB/SH)
//   ReadDataM   load result, sign/zero-extended
//   BusyM       stall request to hazard logic
//   MisalignM   one-cycle misaligned-request flag
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_unit_if;
   logic        MemReadM;
   logic        MemWriteM;
   logic [2:0]  Funct3M;
   logic [31:0] AddressM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadDataM;
   logic        BusyM;
   logic        MisalignM;

   modport master (
      output MemReadM, MemWriteM, Funct3M, AddressM, WriteDataM,
      input  ReadDataM, BusyM, MisalignM
   );

   modport slave (
      input  MemReadM, MemWriteM, Funct3M, AddressM, WriteDataM,
      output ReadDataM, BusyM, MisalignM
   );
endinterface
`default_nettype wire

// File: rtl/data_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_unit
// Description : Multi-cycle data-memory controller for the RV32 memory stage.
//               Byte/half/word loads and stores against an internal
//               word-organised RAM; stalls the pipeline via BusyM for
//               LATENCY+1 cycles per access.
// Ports       :
//   clk    pipeline clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    data_mem_unit_if.slave (request in, ReadDataM/BusyM/MisalignM out)
// Parameters  :
//   DEPTH_WORDS  RAM depth in 32-bit words (power of two, >= 4)
//   LATENCY      cycles spent in ACCESS per transaction (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_unit #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  wire logic        clk,
   input  wire logic        reset,
   data_mem_unit_if.slave   bus
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW+1:0]   addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [2:0]      f3_q, f3_d;
   logic            store_q, store_d;
   logic [31:0]     rdata_q, rdata_d;

   logic [31:0]     mem_q [DEPTH_WORDS];

   logic            w_req;
   logic            w_aligned;
   logic            w_busy;
   logic            w_misalign;
   logic            w_fire;
   logic            w_we;
   logic [3:0]      w_be;
   logic [31:0]     w_wword;
   logic [31:0]     w_rword;
   logic [7:0]      w_rbyte;
   logic [15:0]     w_rhalf;
   logic [31:0]     w_load;
   logic            w_unused;

   // Address bits above the RAM index are deliberately ignored (wrap-around).
   assign w_unused = ^bus.AddressM;

   assign w_req = bus.MemReadM | bus.MemWriteM;

   // Size comes from funct3[1:0]; codes 11 fall into the word case.
   always_comb begin
      w_aligned = 1'b1;
      case (bus.Funct3M[1:0])
         2'b00:   w_aligned = 1'b1;
         2'b01:   w_aligned = ~bus.AddressM[0];
         default: w_aligned = (bus.AddressM[1:0] == 2'b00);
      endcase
   end

   // The access completes on the edge that ends the final ACCESS cycle.
   assign w_fire = (state_q == ACCESS) && (cnt_q == '0);
   assign w_we   = w_fire & store_q;

   // Store lane steering: data is replicated across lanes and the byte
   // enables pick the lanes that actually change.
   always_comb begin
      w_be    = 4'b1111;
      w_wword = wdata_q;
      case (f3_q[1:0])
         2'b00: begin
            w_be    = 4'b0001 << addr_q[1:0];
            w_wword = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            w_be    = addr_q[1] ? 4'b1100 : 4'b0011;
            w_wword = {2{wdata_q[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wword = wdata_q;
         end
      endcase
   end

   // Load formatting: select lane(s) then sign/zero-extend on funct3[2].
   assign w_rword = mem_q[addr_q[AW+1:2]];

   always_comb begin
      w_rbyte = w_rword[7:0];
      case (addr_q[1:0])
         2'b00:   w_rbyte = w_rword[7:0];
         2'b01:   w_rbyte = w_rword[15:8];
         2'b10:   w_rbyte = w_rword[23:16];
         default: w_rbyte = w_rword[31:24];
      endcase
   end

   assign w_rhalf = addr_q[1] ? w_rword[31:16] : w_rword[15:0];

   always_comb begin
      w_load = w_rword;
      case (f3_q[1:0])
         2'b00:   w_load = f3_q[2] ? {24'h0, w_rbyte} : {{24{w_rbyte[7]}}, w_rbyte};
         2'b01:   w_load = f3_q[2] ? {16'h0, w_rhalf} : {{16{w_rhalf[15]}}, w_rhalf};
         default: w_load = w_rword;
      endcase
   end

   // Next-state and output decode.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      f3_d       = f3_q;
      store_d    = store_q;
      rdata_d    = rdata_q;
      w_busy     = 1'b0;
      w_misalign = 1'b0;
      case (state_q)
         IDLE: begin
            if (w_req) begin
               if (w_aligned) begin
                  w_busy  = 1'b1;
                  addr_d  = bus.AddressM[AW+1:0];
                  wdata_d = bus.WriteDataM;
                  f3_d    = bus.Funct3M;
                  // Read+write together behaves as a store.
                  store_d = bus.MemWriteM;
                  cnt_d   = CW'(LATENCY - 1);
                  state_d = ACCESS;
               end else begin
                  w_misalign = 1'b1;
               end
            end
         end
         ACCESS: begin
            w_busy = 1'b1;
            if (cnt_q == '0) begin
               if (!store_q) begin
                  rdata_d = w_load;
               end
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            // Same instruction is still on the inputs; ignore it.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Combinational outputs are forced low while reset is held so a request
   // still sitting on the inputs cannot raise a stall during reset.
   assign bus.BusyM     = reset & w_busy;
   assign bus.MisalignM = reset & w_misalign;
   assign bus.ReadDataM = rdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         store_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         store_q <= store_d;
         rdata_q <= rdata_d;
      end
   end

   // RAM contents survive reset; an aborted store never reaches here because
   // reset forces the FSM out of ACCESS.
   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               mem_q[addr_q[AW+1:2]][8*b +: 8] <= w_wword[8*b +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_unit
// Description : Self-checking bench for data_mem_unit. Directed scenarios
//               followed by randomized loads/stores compared against a
//               byte-array reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_unit;

   localparam int DEPTH  = 256;
   localparam int LAT    = 2;
   localparam int NBYTES = DEPTH * 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   data_mem_unit_if bus();

   data_mem_unit #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  ref_mem [NBYTES];
   logic [31:0] exp_rd   = 32'h0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int unsigned acc_size(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
      int unsigned sz   = acc_size(f3);
      int unsigned base = addr % NBYTES;
      logic [31:0] v    = 32'h0;
      for (int i = 0; i < int'(sz); i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
      if (sz < 4 && f3[2] == 1'b0 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
      return v;
   endfunction

   task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      int unsigned sz   = acc_size(f3);
      int unsigned base = addr % NBYTES;
      for (int i = 0; i < int'(sz); i++) ref_mem[base + i] = wd[8*i +: 8];
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      bus.MemReadM   = rd;
      bus.MemWriteM  = wr;
      bus.Funct3M    = f3;
      bus.AddressM   = addr;
      bus.WriteDataM = wd;
   endtask

   // One pipeline memory-stage instruction, held until the stall clears.
   task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input bit scramble, input string tag);
      int cyc;
      bit mis;
      @(negedge clk);
      drive(rd, wr, f3, addr, wd);
      #1;
      mis = (rd | wr) && ((addr % acc_size(f3)) != 0);
      if (!(rd | wr)) begin
         chk({tag, " idle busy"}, 32'(bus.BusyM), 32'd0);
         chk({tag, " idle misalign"}, 32'(bus.MisalignM), 32'd0);
         chk({tag, " idle rdata"}, bus.ReadDataM, exp_rd);
      end else if (mis) begin
         chk({tag, " misalign flag"}, 32'(bus.MisalignM), 32'd1);
         chk({tag, " misalign busy"}, 32'(bus.BusyM), 32'd0);
         chk({tag, " misalign rdata"}, bus.ReadDataM, exp_rd);
      end else begin
         chk({tag, " aligned flag"}, 32'(bus.MisalignM), 32'd0);
         cyc = 0;
         while (bus.BusyM === 1'b1 && cyc < 50) begin
            cyc++;
            @(negedge clk);
            if (scramble)
               drive(1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom);
            #1;
         end
         chk({tag, " stall cycles"}, 32'(cyc), 32'(LAT + 1));
         if (wr) ref_store(f3, addr, wd);
         else    exp_rd = ref_load(f3, addr);
         chk({tag, " rdata"}, bus.ReadDataM, exp_rd);
      end
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
   endtask

   initial begin
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      #1;
      chk("reset busy", 32'(bus.BusyM), 32'd0);
      chk("reset misalign", 32'(bus.MisalignM), 32'd0);
      chk("reset rdata", bus.ReadDataM, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("post-reset busy", 32'(bus.BusyM), 32'd0);
      chk("post-reset rdata", bus.ReadDataM, 32'h0);

      // Directed scenarios.
      op(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, "SW 0x10");
      op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        1'b0, "LW 0x10");
      chk("LW 0x10 literal", bus.ReadDataM, 32'hDEADBEEF);
      op(1'b0, 1'b1, 3'b000, 32'h13, 32'h00000080, 1'b0, "SB 0x13");
      op(1'b1, 1'b0, 3'b000, 32'h13, 32'h0,        1'b0, "LB 0x13");
      chk("LB 0x13 literal", bus.ReadDataM, 32'hFFFFFF80);
      op(1'b1, 1'b0, 3'b100, 32'h13, 32'h0,        1'b0, "LBU 0x13");
      chk("LBU 0x13 literal", bus.ReadDataM, 32'h00000080);
      op(1'b0, 1'b1, 3'b001, 32'h12, 32'h00008001, 1'b0, "SH 0x12");
      op(1'b1, 1'b0, 3'b101, 32'h12, 32'h0,        1'b0, "LHU 0x12");
      chk("LHU 0x12 literal", bus.ReadDataM, 32'h00008001);
      op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        1'b0, "LW 0x10 after SH");
      chk("LW 0x10 after SH literal", bus.ReadDataM, 32'h8001BEEF);
      op(1'b1, 1'b0, 3'b010, 32'h11, 32'h0,        1'b0, "LW 0x11");
      op(1'b0, 1'b1, 3'b001, 32'h13, 32'h0000FFFF, 1'b0, "SH 0x13");
      op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        1'b0, "LW 0x10 after misalign");
      op(1'b0, 1'b1, 3'b010, 32'h400, 32'h12345678, 1'b0, "SW 0x400");
      op(1'b1, 1'b0, 3'b010, 32'h000, 32'h0,        1'b0, "LW 0x000 wrap");
      chk("wrap literal", bus.ReadDataM, 32'h12345678);
      op(1'b1, 1'b1, 3'b010, 32'h24, 32'hCAFEF00D, 1'b0, "RW 0x24");

      // Reset in the middle of a store's ACCESS phase.
      op(1'b0, 1'b1, 3'b010, 32'h20, 32'h55AA1234, 1'b0, "SW 0x20 prior");
      @(negedge clk);
      drive(1'b0, 1'b1, 3'b010, 32'h20, 32'hAAAAAAAA);
      @(negedge clk);
      #1;
      chk("midop busy before reset", 32'(bus.BusyM), 32'd1);
      reset = 1'b0;
      #1;
      chk("midop busy in reset", 32'(bus.BusyM), 32'd0);
      chk("midop rdata in reset", bus.ReadDataM, 32'h0);
      exp_rd = 32'h0;
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      op(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, "LW 0x20 after abort");
      chk("abort literal", bus.ReadDataM, 32'h55AA1234);

      // Give every word a known value, then randomized traffic.
      for (int w = 0; w < DEPTH; w++)
         op(1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom, 1'b0, "fill");

      for (int n = 0; n < 400; n++) begin
         int unsigned kind = $urandom_range(0, 9);
         logic [2:0]  f3   = 3'($urandom);
         logic [31:0] addr = $urandom;
         logic        rd   = (kind >= 1 && kind <= 4) || kind == 9;
         logic        wr   = (kind >= 5);
         if ($urandom_range(0, 3) != 0)
            addr = addr & ~(32'(acc_size(f3)) - 32'd1);
         op(rd, wr, f3, addr, $urandom, ($urandom_range(0, 1) == 1), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
